stream_pop_ctrl: RTL and testbench
==================================

Name: stream_pop_ctrl

Overview:
- Command-driven sequencer for the stream buffer's four output size classes (4, 8, 16, 64 bytes).
- Accepts commands of the form "pop N chunks of size class S" from the SIMD issue stage and queues them.
- Drives the buffer's per-class oready so that exactly one class is ever requested.
- Gives the downstream consumer a valid/ready/last view of each chunk; the consumer samples the buffer's odata bytes directly on each accepted transfer.

Parameters:
- CQ_DEPTH, 2: command queue entries; power of two, at least 2.
- CNT_W, 16: width of the per-command chunk count.
- BC_W, 32: width of the cumulative popped-byte counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cvalid  in  1  command valid.
- cready  out  1  command queue can accept.
- csize  in  2  size class index: 0=4B, 1=8B, 2=16B, 3=64B.
- ccount  in  CNT_W  number of chunks to pop; 0 is legal.
- sb_ovalid  in  4  per-class ovalid from the stream buffer.
- sb_oready  out  4  per-class oready to the stream buffer; at most one bit set.
- rvalid  out  1  current chunk is available to the consumer.
- rready  in  1  consumer accepts the chunk.
- rlast  out  1  current chunk is the final chunk of its command.
- rsize  out  2  size class of the current chunk.
- done  out  1  one-cycle pulse per completed command.
- abort  in  1  flush the current command and all queued commands.
- busy  out  1  a command is active or the queue is non-empty.
- byte_cnt  out  BC_W  total bytes popped since reset; wraps modulo 2^BC_W.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: state IDLE, queue empty, sb_oready=0, rvalid=0, rlast=0, rsize=0, done=0, busy=0, byte_cnt=0. Reset mid-command drops all state and does not pulse done.
- Command queue:
  - Circular FIFO of CQ_DEPTH entries.
  - cready = !full && !abort.
  - Push on cvalid&&cready.
  - Push and pop in the same cycle are legal when the queue is full: cready stays 0 that cycle, and the next cycle shows one free slot.
- FSM states: IDLE, RUN.
- IDLE:
  - Queue non-empty: pop the head into cur_size and remaining.
  - If count != 0, go to RUN next cycle.
  - If count == 0, stay in IDLE and register done=1 for the next cycle.
  - Each zero-count command costs 1 cycle and never touches sb_oready.
- RUN outputs (all combinational from registered state):
  - rvalid = sb_ovalid[cur_size].
  - rsize = cur_size.
  - rlast = (remaining == 1).
  - sb_oready[cur_size] = rready; all other bits are 0.
- Transfer: occurs when sb_ovalid[cur_size] && rready.
  - remaining decrements by 1.
  - byte_cnt increases by 4, 8, 16 or 64 according to cur_size.
- Last transfer (remaining == 1):
  - done=1 registered for the next cycle.
  - If the queue is non-empty, load the head in the same cycle and stay in RUN, giving zero-bubble back-to-back commands. A zero-count head falls through: its done pulse follows on the next cycle, emitted from IDLE.
  - Otherwise go to IDLE.
- Two consecutive done pulses are legal, one per completed command.
- Stalls: sb_ovalid low holds all state. Holding rready high while ovalid is low is permitted, because the buffer ignores oready without ovalid.
- abort:
  - Highest priority.
  - In the abort cycle, sb_oready=0 and no transfer is counted, even if sb_ovalid and rready are both high.
  - Next cycle: IDLE, queue empty, done=0. A command presented during abort is not accepted.
  - byte_cnt is not cleared.
- busy = (state==RUN) || !empty.
- Width rules:
  - remaining is CNT_W bits; ccount up to 2^CNT_W-1 must complete exactly.
  - byte_cnt addition wraps silently.

Test Plan:
- Reset, then csize=1, ccount=3, with sb_ovalid=4'b0011 and rready=1 held → sb_oready=4'b0010 for exactly 3 cycles; rlast on the 3rd; done one cycle later; byte_cnt=24; busy falls with done.
- Queue 2 commands back-to-back: (3,2) then (0,1) → 3 contiguous transfer cycles, sb_oready 4'b1000,4'b1000,4'b0001 with no bubble; 2 done pulses; byte_cnt=132; a third cvalid sees cready=0 while full.
- Command (2,0) then (2,1) → first done pulse with sb_oready never set; the second command pops 16 bytes; byte_cnt=16.
- Command (3,4) with sb_ovalid[3] toggling 1010… and rready toggling 1100… → transfers only where both are high; remaining and rlast are correct; no other sb_oready bit ever asserts.
- Command (0,100); after 5 transfers, assert abort for 1 cycle with valid and ready high → no transfer in the abort cycle; then IDLE, busy=0, no done; byte_cnt=20; a cvalid during abort is not accepted.
- Set byte_cnt near wrap (BC_W=8 build), then pop 64-byte chunks → byte_cnt wraps modulo 256; assert rst mid-command → all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/stream_pop_ctrl.sv
// stream_pop_ctrl: queues "pop N chunks of class S" commands and sequences the stream buffer's per-class oready.
module stream_pop_ctrl #(
  parameter int CQ_DEPTH = 2,
  parameter int CNT_W    = 16,
  parameter int BC_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cvalid,
  output logic             cready,
  input  logic [1:0]       csize,
  input  logic [CNT_W-1:0] ccount,
  input  logic [3:0]       sb_ovalid,
  output logic [3:0]       sb_oready,
  output logic             rvalid,
  input  logic             rready,
  output logic             rlast,
  output logic [1:0]       rsize,
  output logic             done,
  input  logic             abort,
  output logic             busy,
  output logic [BC_W-1:0]  byte_cnt
);
  localparam int PW = $clog2(CQ_DEPTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [1:0] q_size_q [CQ_DEPTH];
  logic [CNT_W-1:0] q_cnt_q [CQ_DEPTH];
  logic [PW:0] wr_q, wr_d, rd_q, rd_d;
  logic [1:0] cur_size_q, cur_size_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic done_q, done_d;
  logic [BC_W-1:0] byte_cnt_q, byte_cnt_d, chunk_bytes;
  logic empty, full, push, run, xfer, last;
  logic [1:0] head_size;
  logic [CNT_W-1:0] head_cnt;
  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty = wr_q == rd_q;
  assign full = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign cready = !full && !abort;
  assign push = cvalid && cready;
  assign head_size = q_size_q[rd_q[PW-1:0]];
  assign head_cnt = q_cnt_q[rd_q[PW-1:0]];
  assign run = state_q == RUN;
  assign xfer = run && !abort && sb_ovalid[cur_size_q] && rready;
  assign last = xfer && rem_q == CNT_W'(1);
  assign chunk_bytes = cur_size_q == 2'd3 ? BC_W'(64) : BC_W'(4) << cur_size_q;
  assign sb_oready = (run && rready && !abort) ? 4'b0001 << cur_size_q : 4'b0000;
  assign rvalid = run && !abort && sb_ovalid[cur_size_q];
  assign rlast = run && rem_q == CNT_W'(1);
  assign rsize = run ? cur_size_q : 2'd0;
  assign done = done_q;
  assign busy = run || !empty;
  assign byte_cnt = byte_cnt_q;
  // A zero-count head is left queued at a last transfer so IDLE retires it with its own done pulse.
  always_comb begin
    state_d = state_q;
    cur_size_d = cur_size_q;
    rem_d = rem_q;
    done_d = 1'b0;
    rd_d = rd_q;
    wr_d = wr_q + (PW+1)'(push);
    byte_cnt_d = xfer ? byte_cnt_q + chunk_bytes : byte_cnt_q;
    if (abort) begin
      state_d = IDLE;
      rd_d = wr_q;
    end else if ((!run || (last && head_cnt != '0)) && !empty) begin
      rd_d = rd_q + (PW+1)'(1);
      cur_size_d = head_size;
      rem_d = head_cnt;
      state_d = head_cnt != '0 ? RUN : IDLE;
      done_d = last || head_cnt == '0;
    end else if (xfer) begin
      rem_d = rem_q - CNT_W'(1);
      done_d = last;
      state_d = last ? IDLE : RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      cur_size_q <= '0;
      rem_q <= '0;
      done_q <= 1'b0;
      byte_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cur_size_q <= cur_size_d;
      rem_q <= rem_d;
      done_q <= done_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      q_size_q[wr_q[PW-1:0]] <= csize;
      q_cnt_q[wr_q[PW-1:0]] <= ccount;
    end
  end
endmodule

// File: tb/tb_stream_pop_ctrl.sv
// tb_stream_pop_ctrl: directed bench with a transfer scoreboard, built with an 8-bit byte counter to exercise wrap.
module tb_stream_pop_ctrl;
  logic clk = 0, rst = 1, cvalid = 0, rready = 0, abort = 0;
  logic [1:0] csize = 0;
  logic [15:0] ccount = 0;
  logic [3:0] sb_ovalid = 0;
  logic cready, rvalid, rlast, done, busy;
  logic [3:0] sb_oready;
  logic [1:0] rsize;
  logic [7:0] byte_cnt;
  typedef struct {logic [1:0] size; logic last;} ent_t;
  ent_t sb[$];
  ent_t e;
  int total = 0, bad = 0, cycle_n = 0, xfers, dones, first_x, last_x, done_cyc;
  logic [3:0] s_oready, seen_oready;
  logic s_done, s_busy, s_cready, s_rvalid, s_rlast;
  logic [1:0] s_rsize;
  logic [7:0] s_bytes;
  stream_pop_ctrl #(.CQ_DEPTH(2), .CNT_W(16), .BC_W(8)) dut (
    .clk(clk), .rst(rst), .cvalid(cvalid), .cready(cready), .csize(csize), .ccount(ccount),
    .sb_ovalid(sb_ovalid), .sb_oready(sb_oready), .rvalid(rvalid), .rready(rready),
    .rlast(rlast), .rsize(rsize), .done(done), .abort(abort), .busy(busy), .byte_cnt(byte_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    cycle_n++;
    s_oready = sb_oready; s_done = done; s_busy = busy; s_cready = cready;
    s_rvalid = rvalid; s_rlast = rlast; s_rsize = rsize; s_bytes = byte_cnt;
    seen_oready |= sb_oready;
    if (s_done) begin dones++; done_cyc = cycle_n; end
    if ($countones(sb_oready) > 1) chk("oready_onehot", 32'($countones(sb_oready)), 1);
    if (rvalid && rready && !rst) begin
      if (sb.size() == 0) chk("unexpected_xfer", {30'b0, rsize}, 32'hffff);
      else begin
        e = sb.pop_front();
        chk("rsize", rsize, e.size);
        chk("rlast", rlast, e.last);
        chk("oready", sb_oready, 4'b0001 << e.size);
      end
      xfers++;
      if (first_x < 0) first_x = cycle_n;
      last_x = cycle_n;
    end
    @(posedge clk); #1;
  endtask
  task automatic clr();
    xfers = 0; dones = 0; first_x = -1; last_x = -1; done_cyc = -1; seen_oready = 0;
  endtask
  task automatic cmd(input logic [1:0] sz, input int n);
    cvalid = 1; csize = sz; ccount = 16'(n);
    for (int i = 0; i < n; i++) sb.push_back('{size: sz, last: i == n - 1});
    cyc();
    cvalid = 0;
  endtask
  task automatic do_reset();
    rst = 1; cvalid = 0; abort = 0;
    cyc();
    rst = 0;
    sb.delete();
    clr();
  endtask
  initial begin
    clr();
    cyc(); cyc();
    rst = 0;
    sb.delete();
    cyc();
    chk("rst_oready", s_oready, 0);
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_bytes", s_bytes, 0);
    chk("rst_done", s_done, 0);
    chk("rst_cready", s_cready, 1);
    // single command of three 8-byte chunks
    clr();
    sb_ovalid = 4'b0011; rready = 1;
    cmd(2'd1, 3);
    for (int i = 0; i < 30 && dones == 0; i++) cyc();
    chk("t1_xfers", xfers, 3);
    chk("t1_dones", dones, 1);
    chk("t1_done_lat", done_cyc - last_x, 1);
    chk("t1_busy_at_done", s_busy, 0);
    chk("t1_oready_seen", seen_oready, 4'b0010);
    chk("t1_bytes", s_bytes, 24);
    // back-to-back commands with a full queue
    do_reset();
    sb_ovalid = 4'b0000; rready = 1;
    cmd(2'd3, 2);
    cmd(2'd0, 1);
    cmd(2'd2, 0);
    cvalid = 1; csize = 2'd1; ccount = 16'd1;
    cyc();
    chk("t2_full_cready", s_cready, 0);
    cvalid = 0;
    sb_ovalid = 4'b1111;
    for (int i = 0; i < 30 && dones < 3; i++) cyc();
    cyc();
    chk("t2_xfers", xfers, 3);
    chk("t2_contig", last_x - first_x, 2);
    chk("t2_dones", dones, 3);
    chk("t2_bytes", s_bytes, 132);
    // zero-count command then a single 16-byte chunk
    do_reset();
    sb_ovalid = 4'b0100; rready = 1;
    cmd(2'd2, 0);
    cmd(2'd2, 1);
    for (int i = 0; i < 30 && dones == 0; i++) cyc();
    chk("t3_oready_before_done", seen_oready, 0);
    for (int i = 0; i < 30 && dones < 2; i++) cyc();
    cyc();
    chk("t3_dones", dones, 2);
    chk("t3_xfers", xfers, 1);
    chk("t3_bytes", s_bytes, 16);
    // toggling valid and ready on class 3
    do_reset();
    cmd(2'd3, 4);
    seen_oready = 0;
    for (int i = 0; i < 40; i++) begin
      sb_ovalid = {i % 2 == 0, 3'($urandom_range(0, 7))};
      rready = (i / 2) % 2 == 0;
      cyc();
    end
    chk("t4_xfers", xfers, 4);
    chk("t4_dones", dones, 1);
    chk("t4_other_oready", seen_oready & 4'b0111, 0);
    chk("t4_bytes_wrap", s_bytes, 0);
    // abort mid-command
    do_reset();
    sb_ovalid = 4'b0001; rready = 1;
    cmd(2'd0, 100);
    for (int i = 0; i < 30 && xfers < 5; i++) cyc();
    chk("t5_pre_xfers", xfers, 5);
    abort = 1; cvalid = 1; csize = 2'd1; ccount = 16'd1;
    cyc();
    chk("t5_abort_oready", s_oready, 0);
    chk("t5_abort_cready", s_cready, 0);
    abort = 0; cvalid = 0;
    sb.delete();
    for (int i = 0; i < 5; i++) cyc();
    chk("t5_busy", s_busy, 0);
    chk("t5_rvalid", s_rvalid, 0);
    chk("t5_dones", dones, 0);
    chk("t5_xfers", xfers, 5);
    chk("t5_bytes", s_bytes, 20);
    // byte counter wrap, then reset mid-command
    do_reset();
    sb_ovalid = 4'b1111; rready = 1;
    cmd(2'd3, 5);
    for (int i = 0; i < 30 && dones == 0; i++) cyc();
    chk("t6_bytes_wrap", s_bytes, 64);
    cmd(2'd1, 10);
    for (int i = 0; i < 30 && xfers < 8; i++) cyc();
    chk("t6_mid_busy", s_busy, 1);
    do_reset();
    cyc();
    chk("t6_rst_oready", s_oready, 0);
    chk("t6_rst_rvalid", s_rvalid, 0);
    chk("t6_rst_rlast", s_rlast, 0);
    chk("t6_rst_rsize", s_rsize, 0);
    chk("t6_rst_done", s_done, 0);
    chk("t6_rst_busy", s_busy, 0);
    chk("t6_rst_bytes", s_bytes, 0);
    chk("t6_rst_xfers", xfers, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
